// File: rtl/zynet_config_sequencer.sv
// zyNet configuration sequencer: clears zyNet's soft reset, then replays every neuron's weights
// and biases from a local config memory over zyNet's AXI4-Lite write channels, one write at a time.
module zynet_config_sequencer #(
  parameter int unsigned               NUM_LAYERS = 4,
  parameter logic [8*NUM_LAYERS-1:0]   NEURONS    = {8'd10, 8'd10, 8'd30, 8'd30},
  parameter logic [16*NUM_LAYERS-1:0]  WEIGHTS    = {16'd10, 16'd30, 16'd30, 16'd784},
  parameter int unsigned               DATA_WIDTH = 16,
  parameter int unsigned               MEM_AW     = 16
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_rd_en,
  output logic [MEM_AW-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [31:0]           m_axi_awaddr,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [31:0]           m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLR, S_LAYER, S_NEURON, S_FETCH, S_DATA, S_FIN
  } state_e;

  localparam logic [31:0] REG_WEIGHT   = 32'd0;
  localparam logic [31:0] REG_BIAS     = 32'd4;
  localparam logic [31:0] REG_LAYER    = 32'd12;
  localparam logic [31:0] REG_NEURON   = 32'd16;
  localparam logic [31:0] REG_SOFT_RST = 32'd28;

  state_e              state_q, state_d;
  logic                bias_phase_q, bias_phase_d;
  logic [7:0]          layer_q, layer_d;     // 0-based; written to zyNet as layer_q + 1
  logic [7:0]          neuron_q, neuron_d;   // 0-based, written to zyNet as-is
  logic [15:0]         weight_q, weight_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic                issued_q, issued_d;
  logic                awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic [31:0]         awaddr_q, awaddr_d, wdata_q, wdata_d;

  logic [7:0]          cur_neurons;
  logic [15:0]         cur_weights;
  logic                last_layer, last_neuron, last_weight;
  logic                wr_state, tx_done, go_neuron, go_layer;

  always_comb begin
    cur_neurons = '0;
    cur_weights = '0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (layer_q == 8'(i)) begin
        cur_neurons = NEURONS[8*i +: 8];
        cur_weights = WEIGHTS[16*i +: 16];
      end
    end
  end

  // The "- 1" forms are only consulted once the count is known to be nonzero.
  assign last_layer  = (layer_q == 8'(NUM_LAYERS - 1));
  assign last_neuron = (neuron_q == cur_neurons - 8'd1);
  assign last_weight = (weight_q == cur_weights - 16'd1);
  assign wr_state    = (state_q == S_CLR) || (state_q == S_LAYER) ||
                       (state_q == S_NEURON) || (state_q == S_DATA);
  assign tx_done     = wr_state && bready_q && m_axi_bvalid;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= S_IDLE;
      bias_phase_q <= 1'b0;
      layer_q      <= '0;
      neuron_q     <= '0;
      weight_q     <= '0;
      addr_q       <= '0;
      err_q        <= 1'b0;
      issued_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      awaddr_q     <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      bias_phase_q <= bias_phase_d;
      layer_q      <= layer_d;
      neuron_q     <= neuron_d;
      weight_q     <= weight_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      issued_q     <= issued_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      awaddr_q     <= awaddr_d;
      wdata_q      <= wdata_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    bias_phase_d = bias_phase_q;
    layer_d      = layer_q;
    neuron_d     = neuron_q;
    weight_d     = weight_q;
    addr_d       = addr_q;
    err_d        = err_q;
    go_neuron    = 1'b0;
    go_layer     = 1'b0;
    if (tx_done && (m_axi_bresp != 2'b00)) err_d = 1'b1;
    case (state_q)
      S_IDLE: if (start) begin
        state_d      = S_CLR;
        bias_phase_d = 1'b0;
        layer_d      = '0;
        neuron_d     = '0;
        weight_d     = '0;
        addr_d       = '0;
        err_d        = 1'b0;
      end
      S_CLR:    if (tx_done) state_d = S_LAYER;
      S_LAYER:  if (tx_done) begin
        if (cur_neurons != 8'd0) begin
          state_d  = S_NEURON;
          neuron_d = '0;
        end else go_layer = 1'b1;
      end
      S_NEURON: if (tx_done) begin
        if (bias_phase_q || (cur_weights != 16'd0)) begin
          state_d  = S_FETCH;
          weight_d = '0;
        end else go_neuron = 1'b1;
      end
      S_FETCH: begin
        state_d = S_DATA;
        addr_d  = addr_q + MEM_AW'(1);
      end
      S_DATA:   if (tx_done) begin
        if (!bias_phase_q && !last_weight) begin
          state_d  = S_FETCH;
          weight_d = weight_q + 16'd1;
        end else go_neuron = 1'b1;
      end
      S_FIN:    state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
    if (go_neuron) begin
      if (!last_neuron) begin
        state_d  = S_NEURON;
        neuron_d = neuron_q + 8'd1;
      end else go_layer = 1'b1;
    end
    // The weight phase wraps back to layer 1 for biases; the bias phase ends the run.
    if (go_layer) begin
      if (!last_layer) begin
        state_d = S_LAYER;
        layer_d = layer_q + 8'd1;
      end else if (!bias_phase_q) begin
        state_d      = S_LAYER;
        bias_phase_d = 1'b1;
        layer_d      = '0;
      end else state_d = S_FIN;
    end
  end

  always_comb begin
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    issued_d  = issued_q;
    if (wr_state) begin
      if (!issued_q) begin
        issued_d  = 1'b1;
        awvalid_d = 1'b1;
        wvalid_d  = 1'b1;
        case (state_q)
          S_CLR:    begin awaddr_d = REG_SOFT_RST; wdata_d = '0;                        end
          S_LAYER:  begin awaddr_d = REG_LAYER;    wdata_d = 32'(layer_q) + 32'd1;      end
          S_NEURON: begin awaddr_d = REG_NEURON;   wdata_d = 32'(neuron_q);             end
          default:  begin
            // First DATA cycle is the one where the fetched word is on mem_rdata.
            awaddr_d = bias_phase_q ? REG_BIAS : REG_WEIGHT;
            wdata_d  = 32'(mem_rdata);
          end
        endcase
      end else if (bready_q) begin
        if (m_axi_bvalid) begin
          bready_d = 1'b0;
          issued_d = 1'b0;
        end
      end else begin
        if (m_axi_awready) awvalid_d = 1'b0;
        if (m_axi_wready)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) bready_d = 1'b1;
      end
    end
    busy      = (state_q != S_IDLE) && (state_q != S_FIN);
    done      = (state_q == S_FIN);
    mem_rd_en = (state_q == S_FETCH);
  end

  assign err           = err_q;
  assign mem_addr      = addr_q;
  assign m_axi_awaddr  = awaddr_q;
  assign m_axi_awvalid = awvalid_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = 4'hF;
  assign m_axi_wvalid  = wvalid_q;
  assign m_axi_bready  = bready_q;

endmodule
